// File: rtl/clic_vector_unit_pkg.sv
// Shared types and constants for the CLIC vector unit.
// Optional level nesting is enabled with CLIC_NESTING_EN.
package clic_vector_unit_pkg;

   localparam int unsigned ID_W_DEF        = 5;
   localparam int unsigned LVL_W_DEF       = 8;
   localparam int unsigned NEST_DEPTH_DEF  = 4;
   localparam int unsigned MCAUSE_IRQ_BIT  = 31;
   localparam int unsigned VEC_ENTRY_BYTES = 4;

   typedef enum logic [2:0] {
      StIdle,
      StVreq,
      StVresp,
      StRedir,
      StActive
   } vu_state_e;

   // Table entries are word aligned, so the base is forced to a word boundary.
   function automatic logic [31:0] vec_entry_addr(input logic [31:0] base,
                                                  input logic [31:0] id);
      return (base & ~32'(VEC_ENTRY_BYTES - 1)) + (id * VEC_ENTRY_BYTES);
   endfunction

endpackage

// File: rtl/clic_level_stack.sv
// LIFO of saved interrupt levels used for nested (preempting) interrupts.
// Only instantiated when CLIC_NESTING_EN is defined.
module clic_level_stack
   import clic_vector_unit_pkg::*;
#(
   parameter int unsigned LVL_W      = LVL_W_DEF,
   parameter int unsigned NEST_DEPTH = NEST_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             push,
   input  logic             pop,
   input  logic [LVL_W-1:0] push_data,
   output logic [LVL_W-1:0] top,
   output logic             full,
   output logic             empty
);

   localparam int unsigned CNT_W = $clog2(NEST_DEPTH + 1);
   localparam int unsigned IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

   logic [LVL_W-1:0] mem_q [NEST_DEPTH];
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   assign wr_idx = IDX_W'(cnt_q);
   assign rd_idx = IDX_W'(cnt_q - 1'b1);
   assign full   = (cnt_q == CNT_W'(NEST_DEPTH));
   assign empty  = (cnt_q == '0);
   // Reads as zero when empty so the caller can use it directly as the level to restore.
   assign top    = empty ? '0 : mem_q[rd_idx];

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cnt_q <= '0;
         for (int i = 0; i < int'(NEST_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (push && !full) begin
         mem_q[wr_idx] <= push_data;
         cnt_q         <= cnt_q + 1'b1;
      end else if (pop && !empty) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/clic_vector_unit.sv
// Takes the CLIC winner, fetches its handler from the vector table and redirects the core.
// Defining CLIC_NESTING_EN adds a level stack and preemption of active handlers.
module clic_vector_unit
   import clic_vector_unit_pkg::*;
#(
   parameter int unsigned ID_W       = ID_W_DEF,
   parameter int unsigned LVL_W      = LVL_W_DEF,
   parameter int unsigned NEST_DEPTH = NEST_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             irq_valid,
   input  logic [ID_W-1:0]  irq_id,
   input  logic [LVL_W-1:0] irq_level,
   output logic             clic_irq,
   input  logic [31:0]      mtvt_base,
   output logic             vreq_valid,
   output logic [31:0]      vreq_addr,
   input  logic             vreq_ready,
   input  logic             vresp_valid,
   input  logic [31:0]      vresp_data,
   input  logic             vresp_err,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   input  logic             redirect_ready,
   output logic [31:0]      mcause,
   input  logic             mret,
   output logic [LVL_W-1:0] cur_level,
   output logic             vec_err
);

   if (NEST_DEPTH < 1) begin : g_bad_depth
      $error("NEST_DEPTH must be at least 1");
   end

   vu_state_e        state_q, state_d;
   logic [ID_W-1:0]  id_q;
   logic [LVL_W-1:0] level_q;
   logic [LVL_W-1:0] cur_level_q;
   logic [31:0]      pc_q;
   logic [31:0]      mcause_q;
   logic             vec_err_q;

   logic             irq_wins, take_idle, mret_act, resp_ok, resp_err, redir_hs;
   logic             preempt, err_to_active, mret_to_idle;
   logic [LVL_W-1:0] mret_level;

   assign irq_wins  = irq_valid && (irq_level > cur_level_q);
   assign take_idle = (state_q == StIdle) && irq_wins;
   assign mret_act  = (state_q == StActive) && mret;
   assign resp_ok   = (state_q == StVresp) && vresp_valid && !vresp_err;
   assign resp_err  = (state_q == StVresp) && vresp_valid && vresp_err;
   assign redir_hs  = (state_q == StRedir) && redirect_ready;

`ifdef CLIC_NESTING_EN
   logic             stk_full, stk_empty;
   logic [LVL_W-1:0] stk_top;

   clic_level_stack #(
      .LVL_W      (LVL_W),
      .NEST_DEPTH (NEST_DEPTH)
   ) u_level_stack (
      .clk       (clk),
      .resetb    (resetb),
      .push      (preempt),
      .pop       ((mret_act || resp_err) && !stk_empty),
      .push_data (cur_level_q),
      .top       (stk_top),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   // mret wins over a simultaneous preemption; the new winner is re-offered next cycle.
   assign preempt       = (state_q == StActive) && irq_wins && !mret && !stk_full;
   // A non-empty stack while fetching means this entry preempted an active handler.
   assign err_to_active = !stk_empty;
   assign mret_to_idle  = stk_empty;
   assign mret_level    = stk_top;
`else
   assign preempt       = 1'b0;
   assign err_to_active = 1'b0;
   assign mret_to_idle  = 1'b1;
   assign mret_level    = '0;
`endif

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (take_idle) state_d = StVreq;
         StVreq:   if (vreq_ready) state_d = StVresp;
         StVresp: begin
            if (resp_ok) state_d = StRedir;
            else if (resp_err) state_d = err_to_active ? StActive : StIdle;
         end
         StRedir:  if (redirect_ready) state_d = StActive;
         StActive: begin
            if (preempt) state_d = StVreq;
            else if (mret_act && mret_to_idle) state_d = StIdle;
         end
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      vreq_valid     = (state_q == StVreq);
      vreq_addr      = vreq_valid ? vec_entry_addr(mtvt_base, 32'(id_q)) : '0;
      redirect_valid = (state_q == StRedir);
      redirect_pc    = pc_q;
      mcause         = mcause_q;
      cur_level      = cur_level_q;
      vec_err        = vec_err_q;
`ifdef CLIC_NESTING_EN
      clic_irq       = (state_q == StVreq) || (state_q == StVresp) || (state_q == StRedir);
`else
      clic_irq       = (state_q != StIdle);
`endif
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         id_q        <= '0;
         level_q     <= '0;
         cur_level_q <= '0;
         pc_q        <= '0;
         mcause_q    <= '0;
         vec_err_q   <= 1'b0;
      end else begin
         vec_err_q <= resp_err;
         if (take_idle || preempt) begin
            id_q    <= irq_id;
            level_q <= irq_level;
         end
         if (resp_ok) begin
            pc_q <= vresp_data & ~32'h1;
         end
         if (redir_hs) begin
            cur_level_q <= level_q;
            mcause_q    <= 32'(id_q) | (32'h1 << MCAUSE_IRQ_BIT);
         end else if (mret_act) begin
            cur_level_q <= mret_level;
         end
      end
   end

endmodule
